// File: rtl/riscv_data_memory_responder_if.sv
// Data-memory bus between riscv_cpu (master) and riscv_data_memory_responder (slave).
// One request per cycle: mem_read/mem_write strobes qualify address/write_data.
// read_data is registered by the responder; busy high means requests are ignored.
interface riscv_data_memory_responder_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;
  logic        busy;

  modport master (
    output address,
    output write_data,
    output mem_write,
    output mem_read,
    input  read_data,
    input  busy
  );

  modport slave (
    input  address,
    input  write_data,
    input  mem_write,
    input  mem_read,
    output read_data,
    output busy
  );
endinterface

// File: rtl/riscv_data_memory_responder.sv
// Responder for the CPU data-memory bus.
//   - Word RAM of 2**DEPTH_LOG2 32-bit words at byte 0x0.
//   - MMIO at 0x8000_0000: CYCLE_LO (RO), CYCLE_HI (RO, shadow), SCRATCH (RW).
//   - Sticky access_fault on misaligned or unmapped accesses, cleared by reset only.
// Optional feature macro: DMEM_ZERO_INIT_EN. When defined, the RAM is zero-cleared
// one word per cycle after every reset and busy is held high until that finishes.
module riscv_data_memory_responder #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                                clk,
  input  logic                                reset,
  riscv_data_memory_responder_if.slave        data_memory,
  output logic                                access_fault
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  localparam logic [31:0] CycleLoAddr  = 32'h8000_0000;
  localparam logic [31:0] CycleHiAddr  = 32'h8000_0004;
  localparam logic [31:0] ScratchAddr  = 32'h8000_0008;

  // RAM (contents intentionally not reset)
  logic [31:0] mem_q [Depth];

  // Registered state
  logic [31:0] rd_q, rd_d;
  logic        fault_q, fault_d;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] scratch_q, scratch_d;

  // Decode results
  logic [31:0]           addr;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  misaligned;
  logic                  unmapped;
  logic                  bad_access;
  logic                  hit_ram;
  logic                  hit_lo;
  logic                  hit_hi;
  logic                  hit_scratch;

  // Request qualification and RAM write port
  logic                  ready;
  logic                  rd_req;
  logic                  wr_req;
  logic                  cpu_ram_we;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  logic [31:0]           ram_wdata;

  assign addr     = data_memory.address;
  assign word_idx = addr[DEPTH_LOG2+1:2];

  // Address decode into exactly one of {bad, ram, lo, hi, scratch}
  always_comb begin
    misaligned  = (addr[1:0] != 2'b00);
    unmapped    = 1'b0;
    hit_ram     = 1'b0;
    hit_lo      = 1'b0;
    hit_hi      = 1'b0;
    hit_scratch = 1'b0;
    if (!misaligned) begin
      if (!addr[31]) begin
        if ({3'b000, addr[30:2]} < 32'(Depth)) begin
          hit_ram = 1'b1;
        end else begin
          unmapped = 1'b1;
        end
      end else begin
        case (addr)
          CycleLoAddr: hit_lo      = 1'b1;
          CycleHiAddr: hit_hi      = 1'b1;
          ScratchAddr: hit_scratch = 1'b1;
          default:     unmapped    = 1'b1;
        endcase
      end
    end
    bad_access = misaligned | unmapped;
  end

  // Strobes only count once the block is ready (never during zero-init)
  assign rd_req     = ready & data_memory.mem_read;
  assign wr_req     = ready & data_memory.mem_write;
  assign cpu_ram_we = wr_req & hit_ram;

`ifdef DMEM_ZERO_INIT_EN
  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] init_idx_q, init_idx_d;
  logic                  init_we;

  // Init FSM state and sweep index
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInit;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Sweep every RAM word once, then hand over to the CPU
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ready      = 1'b0;
    init_we    = 1'b0;
    unique case (state_q)
      StInit: begin
        init_we    = 1'b1;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == '1) begin
          state_d = StReady;
        end
      end
      StReady: begin
        ready = 1'b1;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  assign ram_we    = ~reset & (init_we | cpu_ram_we);
  assign ram_waddr = init_we ? init_idx_q : word_idx;
  assign ram_wdata = init_we ? 32'h0 : data_memory.write_data;
`else
  assign ready     = 1'b1;
  assign ram_we    = ~reset & cpu_ram_we;
  assign ram_waddr = word_idx;
  assign ram_wdata = data_memory.write_data;
`endif

  // Next-state for read data, fault flag, counter, shadow and scratch
  always_comb begin
    rd_d      = rd_q;
    fault_d   = fault_q;
    shadow_d  = shadow_q;
    scratch_d = scratch_q;
    cycle_d   = cycle_q + 64'd1;

    if ((rd_req | wr_req) && bad_access) begin
      fault_d = 1'b1;
    end

    // Reads see pre-edge state, so a same-cycle write to the same word returns old data
    if (rd_req) begin
      unique case (1'b1)
        hit_ram:     rd_d = mem_q[word_idx];
        hit_lo: begin
          rd_d     = cycle_q[31:0];
          shadow_d = cycle_q[63:32];
        end
        hit_hi:      rd_d = shadow_q;
        hit_scratch: rd_d = scratch_q;
        default:     rd_d = 32'h0;
      endcase
    end

    // CYCLE_LO/HI are read-only; writes there are dropped without a fault
    if (wr_req && hit_scratch) begin
      scratch_d = data_memory.write_data;
    end
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q      <= '0;
      fault_q   <= 1'b0;
      cycle_q   <= '0;
      shadow_q  <= '0;
      scratch_q <= '0;
    end else begin
      rd_q      <= rd_d;
      fault_q   <= fault_d;
      cycle_q   <= cycle_d;
      shadow_q  <= shadow_d;
      scratch_q <= scratch_d;
    end
  end

  // Single write port shared by zero-init and CPU stores
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_waddr] <= ram_wdata;
    end
  end

  assign data_memory.read_data = rd_q;
  assign data_memory.busy      = ~ready;
  assign access_fault          = fault_q;

endmodule
